// File: rtl/lam_unit.sv
// Load/store execution unit: one 32-bit memory access per command over a
// req/ready handshake, with extended load data returned to the register file.
module lam_unit #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lam_new,
   input  logic [8:0]  lam_control,
   input  logic        alu_valid,
   input  logic [31:0] alu_addr,
   output logic [4:0]  rf_rsel,
   input  logic [31:0] rf_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_sel,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ADDR, REQ, WB} state_t;

   state_t      state_q, state_d;
   logic [8:0]  cmd_q, cmd_d;
   logic [1:0]  off_q, off_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        wb_en_q, wb_en_d;
   logic [4:0]  wb_sel_q, wb_sel_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [8:0]  cur_cmd;
   logic [2:0]  cur_f3;
   logic        cur_st;
   logic        legal;
   logic        misal;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [31:0] shifted;
   logic [31:0] ld_data;

   // The command is checked from the live inputs when address and strobe coincide.
   assign cur_cmd = (state_q == IDLE) ? lam_control : cmd_q;
   assign cur_f3  = cur_cmd[7:5];
   assign cur_st  = cur_cmd[8];
   assign rf_rsel = (state_q == IDLE) ? lam_control[4:0] : cmd_q[4:0];

   always_comb begin
      legal = 1'b0;
      case (cur_f3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !cur_st;
         default:                legal = 1'b0;
      endcase
      misal = (cur_f3[1:0] == 2'b01 && alu_addr[0]) ||
              (cur_f3[1:0] == 2'b10 && alu_addr[1:0] != 2'b00);
      st_strb = 4'b1111;
      st_data = rf_rdata;
      case (cur_f3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << alu_addr[1:0];
            st_data = {4{rf_rdata[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << alu_addr[1:0];
            st_data = {2{rf_rdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (cmd_q[7:5])
         3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_data = {24'b0, shifted[7:0]};
         3'b101:  ld_data = {16'b0, shifted[15:0]};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      off_d     = off_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wb_en_d   = 1'b0;
      wb_sel_d  = wb_sel_q;
      wb_data_d = wb_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE, ADDR: begin
            if (state_q == IDLE && lam_new) begin
               cmd_d   = lam_control;
               state_d = ADDR;
            end
            if ((state_q == ADDR || lam_new) && alu_valid) begin
               if (!legal || misal) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  cnt_d   = 8'd0;
                  off_d   = alu_addr[1:0];
                  addr_d  = {alu_addr[31:2], 2'b00};
                  we_d    = cur_st;
                  wstrb_d = cur_st ? st_strb : 4'b0000;
                  wdata_d = cur_st ? st_data : wdata_q;
               end
            end
         end
         REQ: begin
            if (mem_ready) begin
               state_d = WB;
               req_d   = 1'b0;
               done_d  = 1'b1;
               if (!cmd_q[8]) begin
                  wb_data_d = ld_data;
                  wb_sel_d  = cmd_q[4:0];
                  wb_en_d   = (cmd_q[4:0] != 5'd0);
               end
            end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
               state_d = IDLE;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         off_q     <= '0;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wb_en_q   <= 1'b0;
         wb_sel_q  <= '0;
         wb_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         off_q     <= off_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wb_en_q   <= wb_en_d;
         wb_sel_q  <= wb_sel_d;
         wb_data_q <= wb_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign wb_en     = wb_en_q;
   assign wb_sel    = wb_sel_q;
   assign wb_data   = wb_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lam_unit.sv
// Directed bench for lam_unit: loads, stores, errors, wait states,
// timeout and asynchronous reset.
module tb_lam_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lam_new;
   logic [8:0]  lam_control;
   logic        alu_valid;
   logic [31:0] alu_addr;
   logic [4:0]  rf_rsel;
   logic [31:0] rf_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        wb_en;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic        busy;
   logic        done;
   logic        err;

   int n_chk = 0;
   int n_bad = 0;

   lam_unit #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .lam_new(lam_new), .lam_control(lam_control),
      .alu_valid(alu_valid), .alu_addr(alu_addr),
      .rf_rsel(rf_rsel), .rf_rdata(rf_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Register file stand-in: r7 holds the store pattern.
   always_comb begin
      rf_rdata = (rf_rsel == 5'd7) ? 32'h0000_ABCD : {27'b0, rf_rsel};
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [8:0] ctl, input logic [31:0] a,
                        input logic av);
      lam_new     = 1'b1;
      lam_control = ctl;
      alu_valid   = av;
      alu_addr    = a;
      tick();
      lam_new   = 1'b0;
      alu_valid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      mem_ready = 1'b1;
      mem_rdata = d;
      tick();
      mem_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      lam_new = 1'b0;
      lam_control = '0;
      alu_valid = 1'b0;
      alu_addr = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wb", {wb_en, done, err, wb_sel}, 32'd0);
      rst_n = 1'b1;
      tick();

      // LW r5 at 0x100
      issue({1'b0, 3'b010, 5'd5}, 32'h100, 1'b1);
      check("lw_req", 32'(mem_req), 32'd1);
      check("lw_addr", mem_addr, 32'h100);
      check("lw_we", {mem_we, mem_wstrb}, 32'd0);
      respond(32'hDEAD_BEEF);
      check("lw_wb", {done, wb_en, err, wb_sel}, {29'b0, 3'b110} << 5 | 32'd5);
      check("lw_data", wb_data, 32'hDEAD_BEEF);
      check("lw_req_off", 32'(mem_req), 32'd0);
      tick();
      check("lw_idle", {busy, done, wb_en}, 32'd0);

      // LB / LBU at 0x103
      issue({1'b0, 3'b000, 5'd6}, 32'h103, 1'b1);
      respond(32'h8012_3456);
      check("lb_data", wb_data, 32'hFFFF_FF80);
      tick();
      issue({1'b0, 3'b100, 5'd6}, 32'h103, 1'b1);
      respond(32'h8012_3456);
      check("lbu_data", wb_data, 32'h0000_0080);
      tick();

      // SH r7 at 0x202
      issue({1'b1, 3'b001, 5'd7}, 32'h202, 1'b1);
      check("sh_we", 32'(mem_we), 32'd1);
      check("sh_addr", mem_addr, 32'h200);
      check("sh_strb", 32'(mem_wstrb), 32'hC);
      check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      respond(32'h0);
      check("sh_done", {done, wb_en, err}, 32'b100);
      tick();

      // Misaligned LW and illegal funct3
      issue({1'b0, 3'b010, 5'd1}, 32'h101, 1'b1);
      check("mis_err", {err, mem_req, busy, done}, 32'b1000);
      tick();
      check("mis_clear", {err, mem_req}, 32'd0);
      issue({1'b0, 3'b011, 5'd1}, 32'h100, 1'b1);
      check("ill_err", {err, mem_req, busy}, 32'b100);
      tick();

      // LHU via ADDR wait, three wait states
      issue({1'b0, 3'b101, 5'd3}, 32'h0, 1'b0);
      check("addr_wait", {busy, mem_req}, 32'b10);
      alu_valid = 1'b1;
      alu_addr  = 32'h42;
      tick();
      alu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("ws_req", {mem_req, mem_we, mem_wstrb}, 32'b100000);
         check("ws_addr", mem_addr, 32'h40);
         tick();
      end
      respond(32'hF00D_1234);
      check("lhu_data", wb_data, 32'h0000_F00D);
      check("lhu_sel", {wb_en, wb_sel}, {26'b0, 1'b1, 5'd3});
      tick();

      // Timeout: no ready for 16 REQ cycles
      issue({1'b0, 3'b010, 5'd2}, 32'h10, 1'b1);
      for (int i = 0; i < 15; i++) tick();
      check("to_req16", 32'(mem_req), 32'd1);
      tick();
      check("to_err", {err, mem_req, wb_en, done, busy}, 32'b10000);
      tick();

      // Async reset mid-REQ
      issue({1'b1, 3'b010, 5'd4}, 32'h300, 1'b1);
      check("ar_req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_drop", {mem_req, busy}, 32'd0);
      rst_n = 1'b1;
      tick();
      issue({1'b0, 3'b010, 5'd0}, 32'h8, 1'b1);
      check("r0_req", mem_addr, 32'h8);
      respond(32'h1234_5678);
      check("r0_wb", {done, wb_en, err}, 32'b100);
      tick();
      check("r0_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/lam_unit.md
Name: lam_unit

Overview:
- Load/store ("LAM") execution unit. It consumes the decoder's lam_new / lam_control command and the ALU-computed effective address.
- Performs one 32-bit memory transaction over a req/ready handshake.
- Returns sign- or zero-extended load data to the register-file write port.
- Sits between the decoder/ALU demux path and the data memory. Asserts busy so the core stalls.

Parameters:
- MEM_TIMEOUT, 16, cycles in REQ without mem_ready before abort (range 2..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- lam_new  in  1  command strobe, one cycle
- lam_control  in  9  {is_store[8], funct3[7:5], reg[4:0]}; reg = rd for loads, rs2 for stores
- alu_valid  in  1  alu_addr valid (ALU output demuxed to this unit)
- alu_addr  in  32  effective byte address
- rf_rsel  out  5  register-file read select for store data
- rf_rdata  in  32  register-file read data (combinational from rf_rsel)
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {alu_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  memory accepts request / read data valid
- mem_rdata  in  32  read data, valid when mem_ready=1
- wb_en  out  1  register write strobe
- wb_sel  out  5  destination register
- wb_data  out  32  extended load data
- busy  out  1  unit not idle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse (illegal funct3, misaligned access, timeout)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. mem_req, mem_we, wb_en, done, err and busy = 0. mem_addr, mem_wdata, wb_data = 0. mem_wstrb = 0. wb_sel = 0. Internal command and timeout counter cleared. An in-flight mem_req drops immediately, no completion.
- States: IDLE, ADDR, REQ, WB. busy = (state != IDLE).
- rf_rsel = lam_control[4:0] in IDLE, otherwise the latched reg field.
- IDLE: lam_new=1 latches lam_control.
  - If alu_valid is also 1: check address/funct3 and, if OK, latch alu_addr and rf_rdata, then go to REQ.
  - Otherwise go to ADDR.
- ADDR: wait for alu_valid; on it, perform the same check/latch and go to REQ.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value: err pulse, no memory access, return to IDLE.
- Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0): err pulse next cycle, no mem_req, return to IDLE.
- REQ: mem_req=1. addr/we/wdata/wstrb are held stable until mem_ready=1 is sampled at a rising edge.
  - Store: wstrb = 4'b0001<<addr[1:0] (SB), 4'b0011<<addr[1:0] (SH), 4'b1111 (SW). wdata = {4{rs2[7:0]}}, {2{rs2[15:0]}}, or rs2.
  - Load: mem_we=0, mem_wstrb=0.
  - Timeout counter increments each REQ cycle. If it reaches MEM_TIMEOUT with no mem_ready: drop mem_req, err pulse, go to IDLE, no write-back.
- mem_ready sampled: go to WB; load data is registered from mem_rdata.
  - Byte load: rdata>>(8*addr[1:0]), bits [7:0].
  - Half load: rdata>>(8*addr[1:0]), bits [15:0].
  - Extension: sign-extend for LB/LH, zero-extend for LBU/LHU.
- WB (exactly one cycle): done=1. For loads, wb_en=1 unless rd=0 (the access still happens, wb_en stays 0). wb_sel = rd. Stores: wb_en=0. Next state is IDLE.
- Latency: lam_new+alu_valid in cycle 0 → mem_req in cycle 1. mem_ready in cycle k → wb_en/done in cycle k+1. busy low in cycle k+2.
- lam_new while busy: ignored. The core must not issue while busy=1.
- err and done are never asserted together. Outputs other than strobes hold their last value in IDLE.

Test Plan:
- LW: lam_control={0,010,00101}, alu_addr=0x100 with lam_new, mem_ready on 1st REQ cycle, mem_rdata=0xDEADBEEF → mem_addr=0x100, wb_en=1, wb_sel=5, wb_data=0xDEADBEEF. Cycle-1 req, cycle-2 wb.
- LB/LBU: addr=0x103, mem_rdata=0x80123456 → LB wb_data=0xFFFFFF80; LBU wb_data=0x00000080.
- SH: lam_control={1,001,00111}, rf_rdata=0x0000ABCD, addr=0x202 → mem_we=1, mem_addr=0x200, mem_wstrb=4'b1100, mem_wdata=0xABCDABCD, done=1, wb_en=0.
- Misaligned/illegal: LW at 0x101 → err pulse, mem_req never high. funct3=011 load → err.
- Wait states and timeout: mem_ready delayed 3 cycles → request signals stable throughout. With MEM_TIMEOUT=16 and no ready → err after 16 REQ cycles, mem_req drops, no wb_en.
- Async reset mid-REQ: rst_n low between edges → mem_req and busy drop immediately. After release, a new lam_new completes normally; a load to rd=0 gives done=1, wb_en=0.
